// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   This block turns a simple valid/ready command port into APB transfers.
//   Each transfer has a SETUP phase and an ACCESS phase. When a transfer
//   finishes, the block returns exactly one response pulse. The response
//   carries the read data and the slave error flag.
//
// Ports:
//   PCLK, PRESETn       clock (rising edge) and asynchronous active-low reset
//   cmd_valid/ready     command handshake. cmd_ready is high only in IDLE.
//   cmd_write           1 = write, 0 = read
//   cmd_addr/wdata      transfer address and write data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           captured PRDATA (0 for writes and for timeouts)
//   rsp_err             captured PSLVERR, or set by a timeout
//   PSEL..PWDATA        APB requester outputs (all registered)
//   PRDATA/PREADY/
//   PSLVERR             APB completer inputs, sampled only in ACCESS
//
// Configuration:
//   APB_TIMEOUT_EN      If defined, a transfer that stalls for TIMEOUT_CYCLES
//                       ACCESS cycles is aborted with rsp_err=1. If not
//                       defined, ACCESS waits on PREADY with no limit.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Reject an out-of-range stall limit when the design is elaborated.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  // The counter holds the number of stalled ACCESS cycles seen so far.
  // The abort happens in the ACCESS cycle that would make it reach the limit.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // During reset, state_q already reads as IDLE.
  // Gating with PRESETn keeps cmd_ready low while reset is asserted.
  assign cmd_ready = (state_q == ST_IDLE) && PRESETn;

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        // A command is accepted only in IDLE.
        // The address, direction and write data then stay on the bus
        // unchanged until the next command is accepted.
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
      end

      ST_ACCESS: begin
        // If PREADY arrives in the same cycle as the stall limit,
        // the transfer completes normally.
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Reset drops PSEL/PENABLE at once and throws away any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Purpose:
//   Self-checking bench for apb_master_bridge.
//   - Commands are issued with random content.
//   - An abstract memory model computes each expected response, which is
//     queued together with the cycle in which it should appear.
//   - A monitor pops a queue entry whenever rsp_valid is seen and compares.
//   - A second monitor checks SETUP/ACCESS sequencing and that the bus
//     fields stay stable.
//   - An APB slave RAM model answers transfers. Its wait states and error
//     flag are chosen per command.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int TMO   = 4;
  localparam int STUCK = 1000;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cycle;
  } rsp_t;

  rsp_t       rspQ[$];
  int         slvWaitQ[$];
  bit         slvErrQ[$];
  logic [7:0] refMem [256];
  logic [7:0] slvMem [256];
  logic [7:0] expAddr = 8'h00;
  logic [7:0] expWdata = 8'h00;
  logic       expWrite = 1'b0;
  int         totalCount = 0;
  int         badCount = 0;
  int         cycleCnt = 0;
  int         slvWait = 0;
  bit         slvErr = 1'b0;
  bit         prevSetup = 1'b0;

  apb_master_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Counts rising edges. The count is read at falling edges, where it is stable.
  always @(posedge PCLK) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, actual, expected, cycleCnt);
    end
  endtask

  // Response monitor: compares every response pulse against the oldest
  // expectation in the queue.
  always @(negedge PCLK) begin
    rsp_t e;
    if (PRESETn && rsp_valid) begin
      if (rspQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = rspQ.pop_front();
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("rsp_cycle", cycleCnt, e.cycle);
      end
    end
  end

  // Protocol monitor:
  // - SETUP lasts exactly one cycle and is always followed by ACCESS.
  // - The bus fields match the accepted command for as long as PSEL is high.
  // - cmd_ready is low for as long as PSEL is high.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      prevSetup <= 1'b0;
    end else begin
      if (prevSetup) checkOutput("setup_to_access", 32'({PSEL, PENABLE}), 32'd3);
      if (PENABLE)   checkOutput("penable_needs_psel", 32'(PSEL), 32'd1);
      if (PSEL) begin
        checkOutput("paddr", 32'(PADDR), 32'(expAddr));
        checkOutput("pwrite", 32'(PWRITE), 32'(expWrite));
        if (expWrite) checkOutput("pwdata", 32'(PWDATA), 32'(expWdata));
        checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      end
      prevSetup <= PSEL & ~PENABLE;
    end
  end

  // APB slave RAM model:
  // - Drives random junk outside ACCESS, which the bridge must ignore.
  // - In ACCESS, inserts the requested number of wait states, then answers.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      slvWait = 0;
      PREADY  = 1'b0;
    end else if (PSEL && !PENABLE) begin
      slvWait = (slvWaitQ.size() > 0) ? slvWaitQ.pop_front() : 0;
      slvErr  = (slvErrQ.size() > 0) ? slvErrQ.pop_front() : 1'b0;
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = 8'($urandom);
      PSLVERR = 1'($urandom_range(0, 1));
    end else if (PSEL && PENABLE) begin
      if (slvWait > 0) begin
        PREADY  = 1'b0;
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom_range(0, 1));
        slvWait--;
      end else begin
        PREADY  = 1'b1;
        PRDATA  = slvMem[PADDR];
        PSLVERR = slvErr;
      end
    end else begin
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = 8'($urandom);
      PSLVERR = 1'($urandom_range(0, 1));
    end
  end

  // The slave RAM stores write data only when a write completes without error.
  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
      slvMem[PADDR] <= PWDATA;
  end

  // Issues one command and queues the response the memory model predicts.
  // The task is called just after a falling edge and returns one falling
  // edge after the command has been accepted.
  task automatic applyStimulus(input bit w, input logic [7:0] a, input logic [7:0] d,
                               input int waits, input bit err);
    rsp_t e;
    int   budget;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    budget    = 0;
    while (cmd_ready !== 1'b1 && budget < 100) begin
      @(negedge PCLK);
      budget++;
    end
    if (cmd_ready !== 1'b1) begin
      checkOutput("cmd_accept", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    expAddr  = a;
    expWrite = w;
    expWdata = d;
    slvWaitQ.push_back(waits);
    slvErrQ.push_back(err);
    // The command is accepted on the next rising edge, cycleCnt+1.
    // The response should appear two edges after that, plus the wait states.
    if (waits >= STUCK) begin
`ifdef APB_TIMEOUT_EN
      e.rdata = 8'h00;
      e.err   = 1'b1;
      e.cycle = cycleCnt + 3 + (TMO - 1);
      rspQ.push_back(e);
`endif
    end else begin
      e.rdata = w ? 8'h00 : refMem[a];
      e.err   = err;
      e.cycle = cycleCnt + 3 + waits;
      if (w && !err) refMem[a] = d;
      rspQ.push_back(e);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (rspQ.size() > 0 && budget < 100) begin
      @(negedge PCLK);
      budget++;
    end
    checkOutput("rsp_drained", rspQ.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      refMem[i] = 8'h00;
      slvMem[i] = 8'h00;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle: all outputs are 0, and cmd_ready is 0 while reset is held.
    PRESETn = 1'b0;
    repeat (5) @(negedge PCLK);
    checkOutput("reset_outputs",
                32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready}),
                32'd0);
    PRESETn = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge PCLK);

    // Directed cases:
    // - write 0xA5 to 0x12 with a zero-wait slave
    // - read it back
    // - read again with 3 wait states and a slave error
    applyStimulus(1'b1, 8'h12, 8'hA5, 0, 1'b0);
    applyStimulus(1'b0, 8'h12, 8'h00, 0, 1'b0);
    applyStimulus(1'b0, 8'h12, 8'h00, 3, 1'b1);
    waitDrain();

    // Random mix of reads and writes to a small address window.
    // Wait states and errors vary, with occasional idle gaps.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
    end
    waitDrain();

    // Reset during ACCESS: the bus drops at once and no response is issued.
    applyStimulus(1'b0, 8'h05, 8'h00, 5, 1'b0);
    @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    rspQ.delete();
    #1;
    checkOutput("reset_mid_bus", 32'({PSEL, PENABLE, cmd_ready}), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    applyStimulus(1'b1, 8'h20, 8'h3C, 0, 1'b0);
    applyStimulus(1'b0, 8'h20, 8'h00, 1, 1'b0);
    waitDrain();

    // Slave never asserts PREADY.
    applyStimulus(1'b0, 8'h12, 8'h00, STUCK, 1'b0);
`ifdef APB_TIMEOUT_EN
    waitDrain();
`else
    repeat (100) @(negedge PCLK);
    checkOutput("stuck_in_access", 32'({PSEL, PENABLE, cmd_ready}), 32'd6);
    #2;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
`endif
    applyStimulus(1'b0, 8'h12, 8'h00, 0, 1'b0);
    waitDrain();

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester feeding the team's APB slave RAM: PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in.
- Converts a simple valid/ready command port, driven by a CPU model or testbench sequencer, into compliant APB SETUP/ACCESS transfers.
- Returns one response per command, carrying read data and the slave error flag.

Parameters:
- ADDR_WIDTH, 8, APB address width; matches the slave RAM.
- DATA_WIDTH, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY. Used only with APB_TIMEOUT_EN; legal range 1..255.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  captured PRDATA; 0 for writes.
- rsp_err  out  1  captured PSLVERR, or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESETn low, asynchronous): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0.
- All APB and rsp_* outputs are registered. cmd_ready is decoded from state: 1 only in IDLE, and 0 while PRESETn is low.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0. On cmd_valid & cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, set PSEL=1, go SETUP.
  - SETUP: exactly one cycle with PSEL=1, PENABLE=0. Always go ACCESS, setting PENABLE=1.
  - ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable.
    - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_err = PSLVERR; pulse rsp_valid for the next cycle; clear PSEL/PENABLE; go IDLE.
    - PREADY=0: stay in ACCESS.
- Latency with zero-wait slave: command accepted at edge N; SETUP during cycle N+1; ACCESS during N+2; rsp_valid high during N+3, coinciding with cmd_ready=1.
- Throughput: one transfer per 3 cycles, with no back-to-back SETUP.
- cmd_valid while busy: ignored (cmd_ready=0). The sender holds the command.
- PADDR/PWRITE/PWDATA keep their last values in IDLE; only PSEL gates validity.
- rsp_rdata/rsp_err hold their values until the next response. rsp_valid is high for exactly one cycle.
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS.
- Reset mid-transfer: PSEL/PENABLE drop immediately, no response is issued, and the in-flight command is lost.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: rsp_valid next cycle, rsp_err=1, rsp_rdata=0, go IDLE.
  - PREADY=1 in the same cycle as the limit wins and completes normally.
- Undefined: no counter logic is compiled; ACCESS waits on PREADY indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; cmd_ready=1 after PRESETn rises.
- Write addr=0x12, data=0xA5, PREADY=1 -> SETUP with PSEL=1/PENABLE=0, then ACCESS with PADDR=0x12, PWDATA=0xA5, PWRITE=1; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr=0x12 from slave RAM model -> rsp_rdata=0xA5, rsp_err=0; PWRITE=0 throughout.
- Read with PREADY low for 3 ACCESS cycles and PSLVERR=1 on the ready cycle -> ACCESS lasts 4 cycles with PADDR stable; rsp_err=1; cmd_ready=0 throughout.
- PRESETn low during ACCESS -> PSEL/PENABLE 0 the same cycle, no rsp_valid; the next command completes normally.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0. Without the macro, the bridge remains in ACCESS after 100 cycles.
